pushbutton_axil_slave: RTL and testbench

AXI4-Lite responder for the pushbutton peripheral. It sits behind the AXI interconnect and is driven by the PS or the master VIP. It exposes four read/write control and scratch registers, plus a status register and an event register for NUM_BTN debounced pushbuttons, and drives a level interrupt to the PS.

---
 rtl/pushbutton_axil_slave.sv | 218 +++++++++++++++++++++
 tb/tb_pushbutton_axil_slave.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_axil_slave.sv
// AXI4-Lite register slave for the pushbutton peripheral.
//
// Registers (word index = ADDR[4:2]):
//   0 CTRL      RW, bit0 = irq_en
//   1 MASK      RW, bits [NUM_BTN-1:0] gate each button's event into the interrupt
//   2 SCRATCH0  RW
//   3 SCRATCH1  RW
//   4 STATUS    RO, debounced button levels
//   5 EVENT     sticky rising-edge flags, write-1-to-clear
//   6,7         unmapped, SLVERR
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*     AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*        AXI4-Lite read address and data channels
//   btn_in              raw asynchronous pushbutton levels
//   btn_irq             registered level interrupt
module pushbutton_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_BTN            = 4,
  parameter int DEBOUNCE_CYCLES    = 100000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_BTN-1:0]              btn_in,
  output logic                            btn_irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WrIdle, WrAck, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdAck, RdData} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [DW-1:0] ctrl_q, mask_q, scratch0_q, scratch1_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q, rd_mux;
  logic          irq_q;

  logic [NUM_BTN-1:0]           sync1_q, sync2_q;
  logic [NUM_BTN-1:0]           deb_q, deb_d;
  logic [NUM_BTN-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]           event_q, event_d, evt_clr;

  logic          wr_fire, rd_fire;
  logic [2:0]    wr_idx, rd_idx;
  logic [DW-1:0] lane_mask;

  // Address LSBs and protection bits carry no meaning for this block.
  logic unused_in;
  assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_fire = (wr_state_q == WrAck);
  assign rd_fire = (rd_state_q == RdAck);
  assign wr_idx  = S_AXI_AWADDR[4:2];
  assign rd_idx  = S_AXI_ARADDR[4:2];

  assign S_AXI_AWREADY = (wr_state_q == WrAck);
  assign S_AXI_WREADY  = (wr_state_q == WrAck);
  assign S_AXI_BVALID  = (wr_state_q == WrResp);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rd_state_q == RdAck);
  assign S_AXI_RVALID  = (rd_state_q == RdData);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign btn_irq       = irq_q;

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WrIdle:  if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_d = WrAck;
      WrAck:   wr_state_d = WrResp;
      WrResp:  if (S_AXI_BREADY) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  // ----------------------------------------------------------------- read FSM
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RdIdle:  if (S_AXI_ARVALID) rd_state_d = RdAck;
      RdAck:   rd_state_d = RdData;
      RdData:  if (S_AXI_RREADY) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  // Byte-lane strobes expanded to a bit mask.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < SW; b++) begin
      lane_mask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_val,
                                          input logic [DW-1:0] new_val,
                                          input logic [DW-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      3'd0:    rd_mux = ctrl_q;
      3'd1:    rd_mux = mask_q;
      3'd2:    rd_mux = scratch0_q;
      3'd3:    rd_mux = scratch1_q;
      3'd4:    rd_mux = DW'(deb_q);
      3'd5:    rd_mux = DW'(event_q);
      default: rd_mux = '0;
    endcase
  end

  // ----------------------------------------------------------------- debounce
  // A button's debounced level flips only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreeing cycle restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Set is ORed in after the clear so a simultaneous rise wins.
  always_comb begin
    evt_clr = '0;
    if (wr_fire && (wr_idx == 3'd5)) evt_clr = S_AXI_WDATA[NUM_BTN-1:0] & lane_mask[NUM_BTN-1:0];
    event_d = (event_q & ~evt_clr) | (deb_d & ~deb_q);
  end

  // ------------------------------------------------------------------ storage
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      ctrl_q     <= '0;
      mask_q     <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
      bresp_q    <= RespOkay;
      rresp_q    <= RespOkay;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      event_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      event_q    <= event_d;
      irq_q      <= ctrl_q[0] & |(event_q & mask_q[NUM_BTN-1:0]);

      if (wr_fire) begin
        bresp_q <= wr_idx[2] && wr_idx[1] ? RespSlvErr : RespOkay;
        case (wr_idx)
          3'd0:    ctrl_q     <= merge(ctrl_q, S_AXI_WDATA, lane_mask);
          3'd1:    mask_q     <= merge(mask_q, S_AXI_WDATA, lane_mask);
          3'd2:    scratch0_q <= merge(scratch0_q, S_AXI_WDATA, lane_mask);
          3'd3:    scratch1_q <= merge(scratch1_q, S_AXI_WDATA, lane_mask);
          default: ;
        endcase
      end

      // Sampled from pre-edge register values, so a same-edge write is not seen.
      if (rd_fire) begin
        rdata_q <= rd_mux;
        rresp_q <= rd_idx[2] && rd_idx[1] ? RespSlvErr : RespOkay;
      end
    end
  end

endmodule

// File: tb/tb_pushbutton_axil_slave.sv
module tb_pushbutton_axil_slave;

  localparam int NB = 4;
  localparam int DC = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic        btn_irq;

  always #5 ACLK = ~ACLK;

  pushbutton_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .btn_in(btn_in), .btn_irq(btn_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic [1:0] wq[$];
  rd_exp_t    rq[$];

  // Reference model state
  logic [31:0]   m_reg [4];
  logic [NB-1:0] m_deb, m_ev, m_last;
  int            m_run [NB];
  bit            hold_b = 1'b0;
  bit            hold_r = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_deb = '0;
    m_ev  = '0;
  endtask

  // A level counts as debounced once the raw input has held it for DC cycles
  // plus synchronizer slack; the bench never produces runs in the gray zone.
  initial begin
    m_reset();
    m_last = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    forever begin
      @(posedge ACLK);
      if (ARESET) begin
        m_last = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (btn_in[i] == m_last[i]) m_run[i]++;
          else begin
            m_run[i]  = 1;
            m_last[i] = btn_in[i];
          end
          if (m_run[i] >= DC + 3 && m_deb[i] != m_last[i]) begin
            if (m_last[i]) m_ev[i] = 1'b1;
            m_deb[i] = m_last[i];
          end
        end
      end
    end
  end

  function automatic rd_exp_t m_read(input logic [4:0] a);
    rd_exp_t e;
    int idx = int'(a) / 4;
    e.resp = 2'b00;
    if (idx < 4) e.data = m_reg[idx];
    else if (idx == 4) e.data = 32'(m_deb);
    else if (idx == 5) e.data = 32'(m_ev);
    else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  function automatic logic [1:0] m_write(input logic [4:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
    int idx = int'(a) / 4;
    logic [31:0] lanes = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    logic [31:0] clr = d & lanes;
    if (idx < 4) begin
      m_reg[idx] = (m_reg[idx] & ~lanes) | (d & lanes);
      return 2'b00;
    end
    if (idx == 5) m_ev = m_ev & ~clr[NB-1:0];
    return (idx >= 6) ? 2'b10 : 2'b00;
  endfunction

  // Monitor: drives the response-ready signals and scores every handshake.
  initial begin
    rd_exp_t e;
    logic [1:0] eb;
    forever begin
      @(negedge ACLK);
      S_AXI_BREADY = !hold_b && ($urandom_range(0, 3) != 0);
      S_AXI_RREADY = !hold_r && ($urandom_range(0, 3) != 0);
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (wq.size() == 0) fail_note("bresp_unexpected");
        else begin
          eb = wq.pop_front();
          check("bresp", 32'(S_AXI_BRESP), 32'(eb));
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) fail_note("rdata_unexpected");
        else begin
          e = rq.pop_front();
          check("rdata", S_AXI_RDATA, e.data);
          check("rresp", 32'(S_AXI_RRESP), 32'(e.resp));
        end
      end
    end
  end

  task automatic wr_issue(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    wq.push_back(m_write(a, d, s));
    @(negedge ACLK);
    S_AXI_AWADDR  = a;
    S_AXI_WDATA   = d;
    S_AXI_WSTRB   = s;
    S_AXI_AWPROT  = 3'($urandom);
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    do begin
      @(negedge ACLK);
      t++;
    end while (!S_AXI_AWREADY && t < 20);
    if (!S_AXI_AWREADY) fail_note("awready_timeout");
    else check("wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
  endtask

  task automatic rd_issue(input logic [4:0] a);
    int t = 0;
    rq.push_back(m_read(a));
    @(negedge ACLK);
    S_AXI_ARADDR  = a;
    S_AXI_ARPROT  = 3'($urandom);
    S_AXI_ARVALID = 1'b1;
    do begin
      @(negedge ACLK);
      t++;
    end while (!S_AXI_ARREADY && t < 20);
    if (!S_AXI_ARREADY) fail_note("arready_timeout");
    @(posedge ACLK);
    #1;
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((wq.size() != 0 || rq.size() != 0) && t < 100) begin
      @(negedge ACLK);
      t++;
    end
    if (wq.size() != 0 || rq.size() != 0) begin
      fail_note("response_timeout");
      wq.delete();
      rq.delete();
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_issue(a, d, s);
    drain();
  endtask

  task automatic rd(input logic [4:0] a);
    rd_issue(a);
    drain();
  endtask

  task automatic check_irq();
    repeat (2) @(negedge ACLK);
    check("btn_irq", 32'(btn_irq), 32'(m_reg[0][0] & |(m_ev & m_reg[1][NB-1:0])));
  endtask

  // Optional short glitch of length glen (< DC), then settle on target.
  task automatic btn_phase(input logic [NB-1:0] target, input logic [NB-1:0] glitch,
                           input int glen);
    if (glitch != '0) begin
      @(negedge ACLK);
      btn_in = btn_in ^ glitch;
      repeat (glen - 1) @(negedge ACLK);
      @(negedge ACLK);
      btn_in = btn_in ^ glitch;
      repeat (2) @(negedge ACLK);
    end
    @(negedge ACLK);
    btn_in = target;
    repeat (DC + 8) @(negedge ACLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_rdata;
    logic [1:0]  held_bresp;
    int t;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
    check("rst_irq", 32'(btn_irq), 32'd0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    // Basic RW registers
    for (int i = 0; i < 4; i++) wr(5'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) rd(5'(i * 4));

    // Byte-lane write
    wr(5'h08, 32'h0000_0003, 4'hF);
    wr(5'h08, 32'hAABB_CCDD, 4'b0010);
    rd(5'h08);

    // Short glitch is filtered, long hold is accepted
    btn_phase(4'b0000, 4'b0001, DC - 1);
    rd(5'h10);
    rd(5'h14);
    btn_phase(4'b0001, 4'b0000, 0);
    rd(5'h10);
    rd(5'h14);
    wr(5'h00, 32'h1, 4'hF);
    wr(5'h04, 32'h1, 4'hF);
    check_irq();

    // EVENT clear, STATUS read-only
    wr(5'h14, 32'h1, 4'hF);
    check_irq();
    rd(5'h14);
    rd(5'h10);
    wr(5'h10, 32'h1, 4'hF);
    rd(5'h10);

    // Unmapped slots
    rd(5'h18);
    wr(5'h1C, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 4; i++) rd(5'(i * 4));

    // Randomized traffic and button activity
    for (int it = 0; it < 80; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 4) wr(5'($urandom), $urandom, 4'($urandom));
      else if (r < 8) rd(5'($urandom));
      else btn_phase(NB'($urandom), NB'($urandom), $urandom_range(1, DC - 1));
      check_irq();
    end

    // Stalled responses, queued second request, then reset mid-stall
    hold_b = 1'b1;
    hold_r = 1'b1;
    @(negedge ACLK);
    wr_issue(5'h08, 32'h1234_5678, 4'hF);
    rd_issue(5'h08);
    t = 0;
    while (!(S_AXI_BVALID && S_AXI_RVALID) && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    if (!(S_AXI_BVALID && S_AXI_RVALID)) fail_note("stall_valid_timeout");
    held_rdata = S_AXI_RDATA;
    held_bresp = S_AXI_BRESP;
    check("stall_first_rdata", held_rdata, 32'h1234_5678);
    S_AXI_AWADDR  = 5'h00;
    S_AXI_WDATA   = 32'hFFFF_FFFF;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 5'h04;
    S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      check("stall_bvalid", 32'(S_AXI_BVALID), 32'd1);
      check("stall_bresp", 32'(S_AXI_BRESP), 32'(held_bresp));
      check("stall_rvalid", 32'(S_AXI_RVALID), 32'd1);
      check("stall_rdata", S_AXI_RDATA, held_rdata);
      check("stall_awready", 32'(S_AXI_AWREADY), 32'd0);
      check("stall_arready", 32'(S_AXI_ARREADY), 32'd0);
    end
    #2;
    ARESET = 1'b1;
    #1;
    check("arst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("arst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("arst_rdata", S_AXI_RDATA, 32'd0);
    check("arst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("arst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("arst_irq", 32'(btn_irq), 32'd0);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    wq.delete();
    rq.delete();
    m_reset();
    hold_b = 1'b0;
    hold_r = 1'b0;
    btn_in = '0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (DC + 8) @(negedge ACLK);
    for (int i = 0; i < 6; i++) rd(5'(i * 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
